// File: rtl/bus_master_if_pkg.sv
// Shared constants and types for the per-core bus master interface.
// Bus handshake signals are active-low: ENABLE_N asserts, DISABLE_N releases.
package bus_master_if_pkg;

  localparam logic ENABLE_N  = 1'b0;
  localparam logic DISABLE_N = 1'b1;

  localparam int BUS_ADDR_WIDTH = 32;
  localparam int DATA_WIDTH     = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WR   = 3'd2,
    ST_RD   = 3'd3,
    ST_DONE = 3'd4
  } bm_state_t;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_wbuf.sv
// Posted-write buffer: synchronous FIFO of {addr,data} with wrap-bit pointers.
// Pushes are dropped when full unless a pop frees the slot in the same cycle.
module bus_wbuf #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic                    i_push,
  input  logic [AW-1:0]           i_addr,
  input  logic [DW-1:0]           i_data,
  input  logic                    i_pop,
  output logic [AW-1:0]           o_head_addr,
  output logic [DW-1:0]           o_head_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] r_addr_mem [DEPTH];
  logic [DW-1:0] r_data_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_wr_idx = (DEPTH > 1) ? r_wr_ptr[IW-1:0] : '0;
  assign w_rd_idx = (DEPTH > 1) ? r_rd_ptr[IW-1:0] : '0;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  // Full when the wrap bits differ and the index bits match.
  assign o_full  = ((r_wr_ptr ^ r_rd_ptr) == PW'(DEPTH));
  assign o_count = r_wr_ptr - r_rd_ptr;

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_head_addr = r_addr_mem[w_rd_idx];
  assign o_head_data = r_data_mem[w_rd_idx];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_addr_mem[w_wr_idx] <= i_addr;
      r_data_mem[w_wr_idx] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/bus_master_if.sv
// Per-core bus master: posts stores into bus_wbuf, stalls loads until bus data returns,
// and runs the breq_/bgrt_ handshake. Strobes are gated by bgrt_ so they never fire ungranted.
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W   = BUS_ADDR_WIDTH,
  parameter int DATA_W   = DATA_WIDTH,
  parameter int WB_DEPTH = 2,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              breq_,
  input  logic              bgrt_,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_we_,
  output logic              bus_rd_,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [2:0]        dbg_state
);

  localparam int CW = cnt_width(RD_LAT);
  localparam int PW = $clog2(WB_DEPTH) + 1;

  bm_state_t         r_state;
  bm_state_t         w_next;
  logic [CW-1:0]     r_rd_cnt;
  logic [CW-1:0]     w_rd_cnt_nxt;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [ADDR_W-1:0] r_rd_addr;

  logic              w_store;
  logic              w_load;
  logic              w_granted;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_more_wr;
  logic              w_rd_last;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [PW-1:0]     w_count;

  bus_wbuf #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .reset_      (reset_),
    .i_push      (w_push),
    .i_addr      (cpu_addr),
    .i_data      (cpu_wdata),
    .i_pop       (w_pop),
    .o_head_addr (w_head_addr),
    .o_head_data (w_head_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  // memread+memwrite together is treated as a store; a load already answered
  // (DONE) is no longer pending even though the core still holds memread.
  assign w_store   = cpu_memwrite;
  assign w_load    = cpu_memread & ~cpu_memwrite & (r_state != ST_DONE);
  assign w_granted = (bgrt_ == ENABLE_N);
  assign w_pop     = (r_state == ST_WR) & w_granted & ~w_empty;
  assign w_push    = w_store & (~w_full | w_pop);
  assign w_more_wr = (w_count > PW'(1)) | w_push;
  assign w_rd_last = (r_rd_cnt == CW'(RD_LAT - 1));

  assign cpu_stall = (w_store & w_full & ~w_pop) | w_load;
  assign breq_     = (~w_empty | w_load) ? ENABLE_N : DISABLE_N;
  assign bus_we_   = ((r_state == ST_WR) & w_granted) ? ENABLE_N : DISABLE_N;
  assign bus_rd_   = ((r_state == ST_RD) & w_granted) ? ENABLE_N : DISABLE_N;
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_state = r_state;

  always_comb begin
    bus_addr  = '0;
    bus_wdata = '0;
    case (r_state)
      ST_WR: begin
        bus_addr  = w_head_addr;
        bus_wdata = w_head_data;
      end
      ST_RD:   bus_addr = r_rd_addr;
      default: ;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_rd_cnt_nxt = r_rd_cnt;
    case (r_state)
      ST_IDLE: if (~w_empty | w_load) w_next = ST_REQ;
      ST_REQ: begin
        if (w_empty & ~w_load)  w_next = ST_IDLE;
        else if (w_granted)     w_next = ~w_empty ? ST_WR : ST_RD;
      end
      ST_WR: begin
        if (~w_granted)         w_next = ST_REQ;
        else if (w_more_wr)     w_next = ST_WR;
        else if (w_load)        w_next = ST_RD;
        else                    w_next = ST_IDLE;
      end
      ST_RD: begin
        // Losing the grant restarts the whole read latency on regrant.
        if (~w_granted) begin
          w_next       = ST_REQ;
          w_rd_cnt_nxt = '0;
        end else if (w_rd_last) begin
          w_next       = ST_DONE;
          w_rd_cnt_nxt = '0;
        end else begin
          w_rd_cnt_nxt = r_rd_cnt + CW'(1);
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_state     <= ST_IDLE;
      r_rd_cnt    <= '0;
      r_cpu_rdata <= '0;
      r_rd_addr   <= '0;
    end else begin
      r_state  <= w_next;
      r_rd_cnt <= w_rd_cnt_nxt;
      if ((r_state == ST_RD) && w_granted && w_rd_last) r_cpu_rdata <= bus_rdata;
      if ((w_next == ST_RD) && (r_state != ST_RD))      r_rd_addr   <= cpu_addr;
    end
  end

endmodule
